fetch_queue: RTL

Parametrised instruction-fetch stage with a decoupled prefetch queue. Holds the fetch PC, issues word requests to a pipelined instruction memory with a request/grant handshake, buffers returned instructions with their PCs, and presents them to decode through a valid/ready handshake. A redirect from execute (taken branch or jump) replaces the PC, squashes the queue and in-flight responses, and pulses `flush` to clear the younger pipeline registers. It sits between the PC/instruction memory and the IF/ID register.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          INST_BYTES   = 4;
    localparam int          DEFAULT_XLEN = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [31:0]             inst;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with clear and occupancy count; head is read combinationally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    // Explicit wrap so DEPTH need not be a power of two (in-flight FIFO).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            assert (!(push && !pop && count_q == CNT_W'(DEPTH)));
            assert (!(pop && count_q == '0));
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch with credit-based prefetch queue and redirect squash.
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               XLEN            = 32,
    parameter int               DEPTH           = 4,
    parameter int               MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]  RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready,
    output logic            flush
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_err
`endif
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int OUT_W = cnt_width(MAX_OUTSTANDING);

    logic [XLEN-1:0]    pc_q;
    logic [CNT_W-1:0]   outstanding_q;
    logic [CNT_W-1:0]   discard_q;
    logic               flush_q;
    logic [CNT_W-1:0]   q_count;
    logic [CNT_W:0]     credit_sum;
    logic [XLEN+31:0]   q_head;
    logic [XLEN-1:0]    if_head;
    logic [OUT_W-1:0]   if_count;
    logic [XLEN-1:0]    redirect_target;
    logic               fetch_halt;
    logic               grant;
    logic               rsp;
    logic               accept;
    logic               drop;
    logic               q_pop;

    assign credit_sum = {1'b0, q_count} + {1'b0, outstanding_q};
    assign imem_req   = !rst && !redirect_valid && !fetch_halt
                        && (credit_sum < (CNT_W+1)'(DEPTH))
                        && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign imem_addr  = pc_q;
    assign grant      = imem_req && imem_gnt;
    // Responses with nothing outstanding are strays and are ignored entirely.
    assign rsp        = imem_rvalid && (outstanding_q != '0);
    assign accept     = rsp && (discard_q == '0) && !redirect_valid;
    assign drop       = rsp && (discard_q != '0);
    assign q_pop      = out_valid && out_ready && !redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    assign redirect_target = redirect_pc;
    assign fetch_halt      = misalign_q;
    assign misalign_err    = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 misalign_q <= 1'b0;
        else if (redirect_valid) misalign_q <= (redirect_pc[1:0] != 2'b00);
    end
`else
    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign fetch_halt      = 1'b0;
`endif

    // Stale responses are counted out via discard_q; the in-flight PC FIFO
    // only ever holds PCs of requests granted since the last redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            flush_q       <= 1'b0;
        end else begin
            assert (outstanding_q <= CNT_W'(MAX_OUTSTANDING));
            assert (discard_q <= outstanding_q);
            assert (discard_q != '0 || CNT_W'(if_count) == outstanding_q);
            flush_q <= redirect_valid;
            if (redirect_valid) begin
                pc_q          <= redirect_target;
                outstanding_q <= outstanding_q - CNT_W'(rsp);
                discard_q     <= outstanding_q - CNT_W'(rsp);
            end else begin
                if (grant) pc_q <= pc_q + XLEN'(INST_BYTES);
                outstanding_q <= outstanding_q + CNT_W'(grant) - CNT_W'(rsp);
                if (drop) discard_q <= discard_q - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(.WIDTH(XLEN + 32), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (accept),
        .push_data ({if_head, imem_rdata}),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_inflight (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (grant),
        .push_data (pc_q),
        .pop       (accept),
        .head_data (if_head),
        .count     (if_count)
    );

    assign out_valid         = (q_count != '0);
    assign {out_pc, out_inst} = q_head;
    assign flush             = flush_q;

endmodule
